// File: rtl/counter_bank_if.sv
// Control and observation bundle for counter_bank: run/mode/clear/load go in,
// the packed counter values, per-channel flags and the LED tap come out.
interface counter_bank_if #(
    parameter int CW    = 8,
    parameter int NCH   = 2,
    parameter int LED_W = 6
);
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

    logic                run;
    logic [2*NCH-1:0]    mode;
    logic                clear;
    logic                ld_en;
    logic [CHW-1:0]      ld_ch;
    logic [CW-1:0]       ld_val;
    logic [NCH*CW-1:0]   data_out;
    logic [NCH-1:0]      sat;
    logic [NCH-1:0]      wrap;
    logic [LED_W-1:0]    led;

    modport master (
        output run, mode, clear, ld_en, ld_ch, ld_val,
        input  data_out, sat, wrap, led
    );

    modport slave (
        input  run, mode, clear, ld_en, ld_ch, ld_val,
        output data_out, sat, wrap, led
    );
endinterface : counter_bank_if

// File: rtl/counter_bank.sv
// Bank of NCH cascaded CW-bit counters. Each channel holds, wraps up, saturates
// up at LIMIT or wraps down; channel k advances only when channel k-1 is odd.
module counter_bank #(
    parameter int            CW    = 8,
    parameter int            NCH   = 2,
    parameter logic [CW-1:0] LIMIT = 8'hF0,
    parameter int            LED_W = 6
) (
    input  logic          clk,
    input  logic          reset,
    counter_bank_if.slave bus
);
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {
        MODE_HOLD      = 2'b00,
        MODE_UP_WRAP   = 2'b01,
        MODE_UP_SAT    = 2'b10,
        MODE_DOWN_WRAP = 2'b11
    } mode_e;

    logic [CW-1:0]  cnt_q [NCH];
    logic [CW-1:0]  cnt_d [NCH];
    logic [NCH-1:0] wrap_q;
    logic [NCH-1:0] wrap_d;
    logic [NCH-1:0] stb;
    logic           ld_in_range;
    logic           ld_hit;

    // When NCH is a power of two every encodable ld_ch names a real channel.
    if ((1 << CHW) == NCH) begin : g_ld_full
        assign ld_in_range = 1'b1;
    end else begin : g_ld_partial
        assign ld_in_range = (bus.ld_ch < CHW'(NCH));
    end

    assign ld_hit = bus.ld_en && ld_in_range;

    // NOTE: every variable driven here gets a default before any branch, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        stb = '0;
        stb[0] = bus.run;
        // The cascade looks at pre-edge state, so a load on channel k-1 still
        // gates channel k with the value being overwritten.
        for (int k = 1; k < NCH; k++) begin
            stb[k] = stb[k-1]
                   && (mode_e'(bus.mode[2*(k-1) +: 2]) != MODE_HOLD)
                   && cnt_q[k-1][0];
        end
    end

    always_comb begin
        mode_e m;
        m      = MODE_HOLD;
        wrap_d = '0;
        for (int k = 0; k < NCH; k++) begin
            cnt_d[k] = cnt_q[k];
        end

        for (int k = 0; k < NCH; k++) begin
            m = mode_e'(bus.mode[2*k +: 2]);
            if (stb[k]) begin
                unique case (m)
                    MODE_HOLD: ;
                    MODE_UP_WRAP: begin
                        cnt_d[k]  = cnt_q[k] + 1'b1;
                        wrap_d[k] = (cnt_q[k] == '1);
                    end
                    MODE_UP_SAT: begin
                        // Values loaded above LIMIT freeze as well.
                        if (cnt_q[k] < LIMIT) begin
                            cnt_d[k] = cnt_q[k] + 1'b1;
                        end
                    end
                    MODE_DOWN_WRAP: begin
                        cnt_d[k]  = cnt_q[k] - 1'b1;
                        wrap_d[k] = (cnt_q[k] == '0);
                    end
                endcase
            end

            if (ld_hit && (int'(bus.ld_ch) == k)) begin
                cnt_d[k]  = bus.ld_val;
                wrap_d[k] = 1'b0;
            end

            if (bus.clear) begin
                cnt_d[k]  = '0;
                wrap_d[k] = 1'b0;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every counter
    // samples the same pre-edge values of its neighbours. The counters are
    // plain flops, not a RAM, so they can all be cleared by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NCH; k++) begin
                cnt_q[k] <= '0;
            end
            wrap_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
        end
    end

    logic [NCH*CW-1:0] data_w;
    logic [NCH-1:0]    sat_w;

    always_comb begin
        data_w = '0;
        sat_w  = '0;
        for (int k = 0; k < NCH; k++) begin
            data_w[k*CW +: CW] = cnt_q[k];
            sat_w[k] = (mode_e'(bus.mode[2*k +: 2]) == MODE_UP_SAT)
                     && (cnt_q[k] >= LIMIT);
        end
    end

    assign bus.data_out = data_w;
    assign bus.sat      = sat_w;
    assign bus.wrap     = wrap_q;
    assign bus.led      = cnt_q[NCH-1][LED_W-1:0];

endmodule : counter_bank

// File: tb/tb_counter_bank.sv
// Directed bench for counter_bank: a vector table walked edge by edge, then
// multi-cycle sequences for cascade timing, saturation, run gating and reset.
module tb_counter_bank;
    logic clk;
    logic reset;

    int n_checks = 0;
    int n_fail   = 0;

    counter_bank_if #(.CW(8), .NCH(2), .LED_W(6)) cb ();

    counter_bank #(.CW(8), .NCH(2), .LIMIT(8'hF0), .LED_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (cb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       run;
        logic [3:0] mode;
        logic       clr;
        logic       ld;
        logic       ch;
        logic [7:0] val;
        logic [7:0] e0;
        logic [7:0] e1;
        logic [1:0] ew;
        logic [1:0] es;
    } vec_t;

    vec_t vecs [23];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic [3:0] m, input logic c,
                         input logic l, input logic ch, input logic [7:0] v);
        cb.run    = r;
        cb.mode   = m;
        cb.clear  = c;
        cb.ld_en  = l;
        cb.ld_ch  = ch;
        cb.ld_val = v;
    endtask

    task automatic do_reset();
        drive(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 8'h00);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset data_out", 32'(cb.data_out), 32'h0);
        check("reset wrap", 32'(cb.wrap), 32'h0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 8'h00);

        vecs = '{
            '{1'b1, 4'b0101, 1'b0, 1'b0, 1'b0, 8'h00, 8'h01, 8'h00, 2'b00, 2'b00},
            '{1'b1, 4'b0101, 1'b0, 1'b0, 1'b0, 8'h00, 8'h02, 8'h01, 2'b00, 2'b00},
            '{1'b1, 4'b0101, 1'b0, 1'b1, 1'b0, 8'hFF, 8'hFF, 8'h01, 2'b00, 2'b00},
            '{1'b1, 4'b0101, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h02, 2'b01, 2'b00},
            '{1'b1, 4'b0101, 1'b0, 1'b0, 1'b0, 8'h00, 8'h01, 8'h02, 2'b00, 2'b00},
            '{1'b1, 4'b0101, 1'b0, 1'b1, 1'b1, 8'hFF, 8'h02, 8'hFF, 2'b00, 2'b00},
            '{1'b1, 4'b0101, 1'b0, 1'b0, 1'b0, 8'h00, 8'h03, 8'hFF, 2'b00, 2'b00},
            '{1'b1, 4'b0101, 1'b0, 1'b0, 1'b0, 8'h00, 8'h04, 8'h00, 2'b10, 2'b00},
            '{1'b1, 4'b1101, 1'b0, 1'b0, 1'b0, 8'h00, 8'h05, 8'h00, 2'b00, 2'b00},
            '{1'b1, 4'b1101, 1'b0, 1'b0, 1'b0, 8'h00, 8'h06, 8'hFF, 2'b10, 2'b00},
            '{1'b1, 4'b0001, 1'b0, 1'b0, 1'b0, 8'h00, 8'h07, 8'hFF, 2'b00, 2'b00},
            '{1'b1, 4'b0001, 1'b0, 1'b0, 1'b0, 8'h00, 8'h08, 8'hFF, 2'b00, 2'b00},
            '{1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 8'h00, 8'h08, 8'hFF, 2'b00, 2'b00},
            '{1'b1, 4'b1000, 1'b0, 1'b0, 1'b0, 8'h00, 8'h08, 8'hFF, 2'b00, 2'b10},
            '{1'b1, 4'b1001, 1'b0, 1'b1, 1'b1, 8'hEF, 8'h09, 8'hEF, 2'b00, 2'b00},
            '{1'b1, 4'b1001, 1'b0, 1'b0, 1'b0, 8'h00, 8'h0A, 8'hF0, 2'b00, 2'b10},
            '{1'b1, 4'b1001, 1'b0, 1'b0, 1'b0, 8'h00, 8'h0B, 8'hF0, 2'b00, 2'b10},
            '{1'b1, 4'b1001, 1'b0, 1'b0, 1'b0, 8'h00, 8'h0C, 8'hF0, 2'b00, 2'b10},
            '{1'b0, 4'b1101, 1'b0, 1'b0, 1'b0, 8'h00, 8'h0C, 8'hF0, 2'b00, 2'b00},
            '{1'b1, 4'b0101, 1'b1, 1'b1, 1'b0, 8'h55, 8'h00, 8'h00, 2'b00, 2'b00},
            '{1'b1, 4'b0011, 1'b0, 1'b1, 1'b0, 8'h01, 8'h01, 8'h00, 2'b00, 2'b00},
            '{1'b1, 4'b0101, 1'b0, 1'b1, 1'b0, 8'h10, 8'h10, 8'h01, 2'b00, 2'b00},
            '{1'b1, 4'b0011, 1'b0, 1'b0, 1'b0, 8'h00, 8'h0F, 8'h01, 2'b00, 2'b00}
        };

        // Table walk from reset; each row is one clock edge.
        do_reset();
        check("sat after reset", 32'(cb.sat), 32'h0);
        check("led after reset", 32'(cb.led), 32'h0);
        for (int i = 0; i < 23; i++) begin
            drive(vecs[i].run, vecs[i].mode, vecs[i].clr, vecs[i].ld, vecs[i].ch, vecs[i].val);
            step();
            check($sformatf("vec%0d cnt0", i), 32'(cb.data_out[7:0]),  32'(vecs[i].e0));
            check($sformatf("vec%0d cnt1", i), 32'(cb.data_out[15:8]), 32'(vecs[i].e1));
            check($sformatf("vec%0d wrap", i), 32'(cb.wrap), 32'(vecs[i].ew));
            check($sformatf("vec%0d sat", i),  32'(cb.sat),  32'(vecs[i].es));
            check($sformatf("vec%0d led", i),  32'(cb.led),  32'(vecs[i].e1[5:0]));
        end

        // Long cascade run: cnt0 = n mod 256, cnt1 = n/2 capped at F0.
        do_reset();
        drive(1'b1, 4'b1001, 1'b0, 1'b0, 1'b0, 8'h00);
        for (int n = 1; n <= 600; n++) begin
            step();
            check($sformatf("casc%0d cnt0", n), 32'(cb.data_out[7:0]), 32'(n % 256));
            check($sformatf("casc%0d cnt1", n), 32'(cb.data_out[15:8]),
                  32'((n / 2 > 240) ? 240 : n / 2));
            check($sformatf("casc%0d wrap", n), 32'(cb.wrap), 32'((n % 256 == 0) ? 1 : 0));
            check($sformatf("casc%0d sat", n),  32'(cb.sat),  32'((n >= 480) ? 2 : 0));
        end

        // Down-wrap from zero.
        do_reset();
        drive(1'b1, 4'b0011, 1'b0, 1'b0, 1'b0, 8'h00);
        step();
        check("down1 cnt0", 32'(cb.data_out[7:0]), 32'hFF);
        check("down1 wrap", 32'(cb.wrap), 32'h1);
        step();
        check("down2 cnt0", 32'(cb.data_out[7:0]), 32'hFE);
        check("down2 wrap", 32'(cb.wrap), 32'h0);

        // Load above LIMIT in saturate mode freezes the counter.
        do_reset();
        drive(1'b0, 4'b1001, 1'b0, 1'b1, 1'b1, 8'hFE);
        step();
        check("satld cnt1", 32'(cb.data_out[15:8]), 32'hFE);
        check("satld sat", 32'(cb.sat), 32'h2);
        drive(1'b1, 4'b1001, 1'b0, 1'b0, 1'b0, 8'h00);
        repeat (6) step();
        check("satld hold cnt1", 32'(cb.data_out[15:8]), 32'hFE);
        check("satld hold cnt0", 32'(cb.data_out[7:0]), 32'h06);
        check("satld hold sat", 32'(cb.sat), 32'h2);

        // Clear beats a simultaneous load.
        drive(1'b0, 4'b0101, 1'b0, 1'b1, 1'b0, 8'h7F);
        step();
        check("pre-clear cnt0", 32'(cb.data_out[7:0]), 32'h7F);
        drive(1'b1, 4'b0101, 1'b1, 1'b1, 1'b0, 8'h55);
        step();
        check("clear data", 32'(cb.data_out), 32'h0);
        check("clear wrap", 32'(cb.wrap), 32'h0);

        // run=0 at all-ones: no movement, no wrap, then wrap on resume.
        drive(1'b0, 4'b0101, 1'b0, 1'b1, 1'b0, 8'hFF);
        step();
        drive(1'b0, 4'b0101, 1'b0, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 10; i++) begin
            step();
            check($sformatf("idle%0d cnt0", i), 32'(cb.data_out[7:0]), 32'hFF);
            check($sformatf("idle%0d wrap", i), 32'(cb.wrap), 32'h0);
        end
        cb.run = 1'b1;
        step();
        check("resume cnt0", 32'(cb.data_out[7:0]), 32'h00);
        check("resume wrap", 32'(cb.wrap), 32'h1);

        // Asynchronous reset between edges, then counting resumes at once.
        drive(1'b0, 4'b0101, 1'b0, 1'b1, 1'b0, 8'h3C);
        step();
        drive(1'b0, 4'b0101, 1'b0, 1'b1, 1'b1, 8'h1E);
        step();
        drive(1'b0, 4'b0101, 1'b0, 1'b0, 1'b0, 8'h00);
        check("pre-rst data", 32'(cb.data_out), 32'h1E3C);
        check("pre-rst led", 32'(cb.led), 32'h1E);
        #2;
        reset = 1'b1;
        #1;
        check("async rst data", 32'(cb.data_out), 32'h0);
        check("async rst led", 32'(cb.led), 32'h0);
        check("async rst wrap", 32'(cb.wrap), 32'h0);
        repeat (2) step();
        check("held rst data", 32'(cb.data_out), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        drive(1'b1, 4'b0101, 1'b0, 1'b0, 1'b0, 8'h00);
        step();
        check("post-rst cnt0", 32'(cb.data_out[7:0]), 32'h01);
        check("post-rst cnt1", 32'(cb.data_out[15:8]), 32'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule : tb_counter_bank

// File: doc/counter_bank.md
COUNTER_BANK -- requirements
Module: counter_bank

Interface
REQ-001 Parameter: CW, 8, counter width per channel in bits, minimum 2.
REQ-002 Parameter: NCH, 2, number of cascaded counter channels, minimum 1.
REQ-003 Parameter: LIMIT, 8'hF0, saturation threshold for mode 10, less than 2^CW.
REQ-004 Parameter: LED_W, 6, LED output width, at most CW.
REQ-005 Port: clk  input  1  clock; all state changes on its rising edge.
REQ-006 Port: reset  input  1  reset, asynchronous, active-high.
REQ-007 Port: run  input  1  global count enable for channel 0 strobe.
REQ-008 Port: mode  input  2*NCH  per-channel mode; bits [2k+1:2k] belong to channel k.
REQ-009 Port: clear  input  1  synchronous clear of all channels.
REQ-010 Port: ld_en  input  1  synchronous load strobe.
REQ-011 Port: ld_ch  input  clog2(NCH), minimum 1  channel index for load.
REQ-012 Port: ld_val  input  CW  load value.
REQ-013 Port: data_out  output  NCH*CW  {cnt[NCH-1],...,cnt[0]}, channel 0 in LSBs, for logic-analyzer data_in.
REQ-014 Port: sat  output  NCH  per-channel saturation flag.
REQ-015 Port: wrap  output  NCH  per-channel one-cycle wrap pulse.
REQ-016 Port: led  output  LED_W  cnt[NCH-1][LED_W-1:0].

Function
REQ-017 Strobe stb[0] SHALL equal run; stb[k] for k>=1 SHALL equal stb[k-1] AND mode[k-1]!=00 AND bit 0 of cnt[k-1] before this edge's update.
REQ-018 Mode 00 hold: cnt[k] unchanged regardless of stb[k].
REQ-019 Mode 01 up-wrap: on stb[k], cnt[k] <= cnt[k]+1 modulo 2^CW.
REQ-020 Mode 10 up-saturate: on stb[k], cnt[k] increments only if cnt[k] < LIMIT; otherwise it holds, including values above LIMIT from a load.
REQ-021 Mode 11 down-wrap: on stb[k], cnt[k] <= cnt[k]-1 modulo 2^CW.
REQ-022 wrap[k] SHALL be registered and high for exactly one cycle, coincident with the new value, after an all-ones->0 (mode 01) or 0->all-ones (mode 11) transition; otherwise low.
REQ-023 sat[k] SHALL be high iff mode[k]==10 and cnt[k] >= LIMIT, derived combinationally from registered state.
REQ-024 Priority per edge: clear > load > count.
REQ-025 clear: all cnt <= 0 and all wrap <= 0 on that edge, regardless of ld_en and run.
REQ-026 load with ld_en=1: cnt[ld_ch] <= ld_val and wrap[ld_ch] <= 0; other channels count normally.
REQ-027 Under load, stb[ld_ch+1] SHALL use channel ld_ch's pre-load bit 0.
REQ-028 ld_ch >= NCH: load ignored, with no effect on any channel.
REQ-029 Mode changes take effect on the next edge; a counter is never reset by a mode change.
REQ-030 run=0: all channels hold and no wrap pulses occur; load and clear still act.
REQ-031 No latency beyond one clock from strobe to updated data_out.

Reset
REQ-032 While reset is high: all cnt = 0, wrap = 0, data_out = 0, led = 0.
REQ-033 reset SHALL act immediately and asynchronously, including mid-count or mid-load.
REQ-034 Counting SHALL resume on the first rising clk edge after reset deasserts.
REQ-035 sat after reset SHALL be 0 for every channel, since LIMIT > 0 is required.

Verification
REQ-036 Default parameters, run=1, mode=4'b1001, from reset:
- after cycle 1: cnt0=1, cnt1=0.
- after 2m cycles: cnt1=m.
- wrap[0] pulses at cycle 256.
- cnt1 reaches F0 at cycle 480, then sat[1]=1 and cnt1 holds F0 indefinitely.
REQ-037 mode0=11, run=1, from reset: first edge gives cnt0=FF with wrap[0]=1 for one cycle; next edge gives cnt0=FE with wrap[0]=0.
REQ-038 mode1=10, ld_en=1, ld_ch=1, ld_val=FE: cnt1=FE, sat[1]=1, and cnt1 stays FE under continued strobes.
REQ-039 clear=1 with ld_en=1, ld_val=55, at cnt0=7F: next cycle all counters 0 and wrap=0.
REQ-040 run=0 for 10 cycles at cnt0=FF, mode0=01: cnt0 stays FF and no wrap pulse occurs; after run=1, next edge gives cnt0=00 with wrap[0]=1.
REQ-041 reset asserted between edges at cnt0=3C, cnt1=1E: data_out=0 and led=0 before the next clk edge.
